mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between icache reads and dcache reads/writes.
// Dcache has priority; icache is granted after STARVE_LIMIT dcache grants made while it waits.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [AW-1:0] LINE_MASK = AW'(32'hFFFF_FFE0);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] starve_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          read_q;
  logic          write_q;

  logic d_req_c;
  logic at_limit_c;
  logic grant_i_c;

  assign d_req_c    = d_read | d_write;
  assign at_limit_c = (starve_q == LIMIT);
  // Icache wins only when alone or when it has waited out the starvation window.
  assign grant_i_c  = i_read & (~d_req_c | at_limit_c);

  // Arbitration state, starvation counter and request latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i_c) begin
            state_q  <= GRANT_I;
            addr_q   <= i_addr;
            read_q   <= 1'b1;
            write_q  <= 1'b0;
            starve_q <= '0;
          end else if (d_req_c) begin
            state_q <= GRANT_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            // Read+write together is a write.
            read_q  <= ~d_write;
            write_q <= d_write;
            if (i_read && !at_limit_c) begin
              starve_q <= starve_q + CW'(1);
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_resp) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q & LINE_MASK;
  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_wdata = wdata_q;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Completion goes only to the owner, and never once reset is asserted.
  assign i_resp = mem_resp & ~rst & (state_q == GRANT_I);
  assign d_resp = mem_resp & ~rst & (state_q == GRANT_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed latency/reset/starvation steps, then random
// traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_addr   (i_addr),
    .i_read   (i_read),
    .i_rdata  (i_rdata),
    .i_resp   (i_resp),
    .d_addr   (d_addr),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_resp   (d_resp),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] rd;
    int           dcount;
    int           resp_cnt;
    logic         seen_i;
    // reference model state
    int           owner;
    int           cnt;
    int           delay;
    int           op;
    int           i_wait;
    int           max_wait;
    logic         prev_idle;
    logic         this_idle;
    logic         resp_now;
    logic         stray;
    logic         pi_p, pd_p, pw_p;
    logic [31:0]  ia_p, da_p, ex_addr;
    logic [255:0] dw_p, ex_wd;
    logic         ex_rd, ex_wr;

    mem_rdata = '0;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick();
    tick();

    // Reset state
    chk_b("rst_mem_read", mem_read, 1'b0);
    chk_b("rst_mem_write", mem_write, 1'b0);
    chk_32("rst_mem_addr", mem_addr, 32'h0);
    chk_256("rst_mem_wdata", mem_wdata, '0);
    mem_resp = 1'b1;
    #1;
    chk_b("rst_i_resp", i_resp, 1'b0);
    chk_b("rst_d_resp", d_resp, 1'b0);

    // Single icache read: strobe at cycle 1, response at cycle 5, idle at 6
    rst = 1'b0; mem_resp = 1'b0;
    i_addr = 32'h0000_1234; i_read = 1'b1;
    tick();
    chk_b("ird_c1_read", mem_read, 1'b1);
    chk_b("ird_c1_write", mem_write, 1'b0);
    chk_32("ird_c1_addr", mem_addr, 32'h0000_1220);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk_b("ird_hold_read", mem_read, 1'b1);
    end
    tick();
    rd = rnd256(); mem_rdata = rd; mem_resp = 1'b1;
    #1;
    chk_b("ird_c5_i_resp", i_resp, 1'b1);
    chk_b("ird_c5_d_resp", d_resp, 1'b0);
    chk_256("ird_c5_i_rdata", i_rdata, rd);
    chk_256("ird_c5_d_rdata", d_rdata, rd);
    i_read = 1'b0;
    tick();
    mem_resp = 1'b0;
    chk_b("ird_c6_read", mem_read, 1'b0);

    // Stray mem_resp while idle is ignored
    mem_resp = 1'b1;
    #1;
    chk_b("idle_resp_i", i_resp, 1'b0);
    chk_b("idle_resp_d", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    chk_b("idle_resp_read", mem_read, 1'b0);
    chk_b("idle_resp_write", mem_write, 1'b0);

    // Dcache write with a pattern; d_resp pulses exactly once
    pat = rnd256();
    d_addr = 32'h8000_0040; d_wdata = pat; d_write = 1'b1;
    tick();
    d_wdata = ~pat;
    chk_b("dwr_write", mem_write, 1'b1);
    chk_b("dwr_read", mem_read, 1'b0);
    chk_32("dwr_addr", mem_addr, 32'h8000_0040);
    chk_256("dwr_wdata", mem_wdata, pat);
    resp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_b("dwr_hold_write", mem_write, 1'b1);
      chk_256("dwr_hold_wdata", mem_wdata, pat);
      if (d_resp) resp_cnt++;
    end
    tick();
    mem_resp = 1'b1;
    #1;
    if (d_resp) resp_cnt++;
    d_write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_resp = 1'b0;
      #1;
      if (d_resp) resp_cnt++;
    end
    chk_b("dwr_done_write", mem_write, 1'b0);
    chk_32("dwr_resp_pulses", 32'(resp_cnt), 32'd1);

    // Simultaneous requests from reset: dcache first, icache right after
    do_reset();
    i_addr = 32'h0000_0100; i_read = 1'b1;
    d_addr = 32'h8000_0200; d_read = 1'b1;
    tick();
    chk_b("sim_d_read", mem_read, 1'b1);
    chk_32("sim_d_addr", mem_addr, 32'h8000_0200);
    tick();
    tick();
    mem_resp = 1'b1;
    #1;
    chk_b("sim_d_resp", d_resp, 1'b1);
    chk_b("sim_i_resp_lo", i_resp, 1'b0);
    d_read = 1'b0;
    tick();
    mem_resp = 1'b0;
    chk_b("sim_gap_read", mem_read, 1'b0);
    tick();
    chk_b("sim_i_read", mem_read, 1'b1);
    chk_32("sim_i_addr", mem_addr, 32'h0000_0100);
    mem_resp = 1'b1;
    #1;
    chk_b("sim_i_resp", i_resp, 1'b1);
    i_read = 1'b0;
    tick();
    mem_resp = 1'b0;

    // Dcache read dropped mid-grant keeps its latched request
    d_addr = 32'h8000_1000; d_read = 1'b1;
    tick();
    chk_b("drop_read_c1", mem_read, 1'b1);
    d_read = 1'b0; d_addr = 32'h0000_DEAD;
    tick();
    chk_b("drop_read_held", mem_read, 1'b1);
    chk_32("drop_addr_held", mem_addr, 32'h8000_1000);
    tick();
    mem_resp = 1'b1;
    #1;
    chk_b("drop_d_resp", d_resp, 1'b1);
    tick();
    mem_resp = 1'b0;
    chk_b("drop_done_read", mem_read, 1'b0);

    // Reset two cycles into a dcache grant abandons it
    d_addr = 32'h8000_2000; d_wdata = rnd256(); d_write = 1'b1;
    tick();
    chk_b("rstg_write", mem_write, 1'b1);
    tick();
    rst = 1'b1; mem_resp = 1'b1;
    #1;
    chk_b("rstg_d_resp_in_rst", d_resp, 1'b0);
    d_write = 1'b0;
    tick();
    rst = 1'b0;
    chk_b("rstg_write_off", mem_write, 1'b0);
    chk_b("rstg_read_off", mem_read, 1'b0);
    chk_32("rstg_addr_zero", mem_addr, 32'h0);
    chk_256("rstg_wdata_zero", mem_wdata, '0);
    #1;
    chk_b("rstg_d_resp_late", d_resp, 1'b0);
    tick();
    mem_resp = 1'b0;
    chk_b("rstg_idle_write", mem_write, 1'b0);

    // Starvation: back-to-back dcache with icache held, two rounds
    do_reset();
    d_addr = 32'h8000_0080; d_read = 1'b1;
    for (int r = 0; r < 2; r++) begin
      dcount = 0; seen_i = 1'b0;
      i_addr = 32'h0000_0040; i_read = 1'b1;
      for (int c = 0; c < 200 && !seen_i; c++) begin
        tick();
        mem_resp = mem_read | mem_write;
        #1;
        if (d_resp) dcount++;
        if (i_resp) begin
          seen_i = 1'b1;
          i_read = 1'b0;
        end
      end
      chk_b("starve_i_granted", seen_i, 1'b1);
      chk_32("starve_d_grants", 32'(dcount), 32'(L));
    end
    d_read = 1'b0;
    tick();
    mem_resp = 1'b0;
    tick();
    chk_b("starve_end_read", mem_read, 1'b0);

    // Random traffic against the transaction-level model
    do_reset();
    owner = 0; cnt = 0; delay = 0; prev_idle = 1'b1;
    pi_p = 1'b0; pd_p = 1'b0; pw_p = 1'b0; ia_p = '0; da_p = '0; dw_p = '0;
    ex_addr = '0; ex_wd = '0; ex_rd = 1'b0; ex_wr = 1'b0;
    i_wait = 0; max_wait = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      mem_resp = 1'b0;
      if (prev_idle) begin
        if (pi_p && (!pd_p || cnt == int'(L))) begin
          owner = 1; cnt = 0;
          ex_addr = ia_p & 32'hFFFF_FFE0; ex_rd = 1'b1; ex_wr = 1'b0;
        end else if (pd_p) begin
          owner = 2;
          if (pi_p && cnt < int'(L)) cnt++;
          ex_addr = da_p & 32'hFFFF_FFE0; ex_rd = ~pw_p; ex_wr = pw_p; ex_wd = dw_p;
        end
        delay = $urandom_range(0, 3);
      end
      this_idle = (owner == 0);
      if (owner == 0) begin
        chk_b("rnd_idle_read", mem_read, 1'b0);
        chk_b("rnd_idle_write", mem_write, 1'b0);
      end else begin
        chk_b("rnd_read", mem_read, ex_rd);
        chk_b("rnd_write", mem_write, ex_wr);
        chk_32("rnd_addr", mem_addr, ex_addr);
        if (owner == 2) chk_256("rnd_wdata", mem_wdata, ex_wd);
      end
      resp_now = 1'b0;
      if (owner != 0) begin
        if (delay == 0) resp_now = 1'b1;
        else delay--;
      end
      stray = (owner == 0) && ($urandom_range(0, 7) == 0);
      mem_resp = resp_now | stray;
      mem_rdata = rnd256();
      #1;
      chk_b("rnd_i_resp", i_resp, resp_now && owner == 1);
      chk_b("rnd_d_resp", d_resp, resp_now && owner == 2);
      chk_256("rnd_i_rdata", i_rdata, mem_rdata);
      chk_256("rnd_d_rdata", d_rdata, mem_rdata);
      if (resp_now) begin
        if (owner == 1) i_read = 1'b0;
        else begin
          d_read = 1'b0;
          d_write = 1'b0;
        end
        owner = 0;
      end
      if (i_read) i_wait++;
      else i_wait = 0;
      if (i_wait > max_wait) max_wait = i_wait;
      if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = {1'b0, 31'($urandom)};
      end
      if (!(d_read || d_write) && $urandom_range(0, 1) == 0) begin
        op = $urandom_range(0, 2);
        d_read = (op != 1);
        d_write = (op != 0);
        d_addr = {1'b1, 31'($urandom)};
        d_wdata = rnd256();
      end
      pi_p = i_read; pd_p = d_read | d_write; pw_p = d_write;
      ia_p = i_addr; da_p = d_addr; dw_p = d_wdata;
      prev_idle = this_idle;
    end
    chk_b("rnd_icache_wait_bounded", max_wait <= 64, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
